// File: rtl/case_9_sdiv_pkg.sv
// Shared types and widths for the case_9 sequential signed divider.
package case_9_sdiv_pkg;

    localparam int DIVIDEND_WIDTH = 17;
    localparam int DIVISOR_WIDTH  = 9;
    localparam int CNT_WIDTH      = $clog2(DIVIDEND_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

endpackage

// File: rtl/case_9_sdiv_step.sv
// One restoring-division step: shift in a dividend bit, subtract the divisor if it fits.
module case_9_sdiv_step #(
    parameter int DIVISOR_WIDTH = case_9_sdiv_pkg::DIVISOR_WIDTH
) (
    input  logic [DIVISOR_WIDTH:0] prem_i,
    input  logic                   bit_i,
    input  logic [DIVISOR_WIDTH:0] dsr_i,
    output logic [DIVISOR_WIDTH:0] prem_o,
    output logic                   qbit_o
);

    logic [DIVISOR_WIDTH+1:0] shifted;
    logic [DIVISOR_WIDTH+1:0] diff;

    // The shifted-out top bit guarantees the divisor fits; otherwise the borrow decides.
    always_comb begin
        shifted = {prem_i, bit_i};
        diff    = {1'b0, shifted[DIVISOR_WIDTH:0]} - {1'b0, dsr_i};
        qbit_o  = shifted[DIVISOR_WIDTH+1] | ~diff[DIVISOR_WIDTH+1];
        prem_o  = qbit_o ? diff[DIVISOR_WIDTH:0] : shifted[DIVISOR_WIDTH:0];
    end

endmodule

// File: rtl/case_9_sdiv_17s_9s_17_seq.sv
// Sequential signed divider (17s / 9s), one quotient bit per ce-active cycle.
// Optional divide-by-zero flag output dz enabled by CASE_9_SDIV_DIVZERO_FLAG_EN.
module case_9_sdiv_17s_9s_17_seq #(
    parameter int ID             = 1,
    parameter int DIVIDEND_WIDTH = case_9_sdiv_pkg::DIVIDEND_WIDTH,
    parameter int DIVISOR_WIDTH  = case_9_sdiv_pkg::DIVISOR_WIDTH
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst,
    input  logic                      ce,
    input  logic                      ap_start,
    output logic                      ap_ready,
    output logic                      ap_idle,
    output logic                      ap_done,
    input  logic [DIVIDEND_WIDTH-1:0] din0,
    input  logic [DIVISOR_WIDTH-1:0]  din1,
    output logic [DIVIDEND_WIDTH-1:0] quot,
    output logic [DIVISOR_WIDTH-1:0]  rem
`ifdef CASE_9_SDIV_DIVZERO_FLAG_EN
    ,
    output logic                      dz
`endif
);
    import case_9_sdiv_pkg::*;

    localparam int W  = DIVIDEND_WIDTH;
    localparam int V  = DIVISOR_WIDTH;
    localparam int CW = $clog2(W + 1);

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   dvd_q, dvd_d;
    logic [V:0]     dsr_q, dsr_d;
    logic [V:0]     prem_q, prem_d;
    logic [W-1:0]   quo_q, quo_d;
    logic           sgn0_q, sgn0_d;
    logic           sgn1_q, sgn1_d;
    logic [W-1:0]   quot_q, quot_d;
    logic [V-1:0]   rem_q, rem_d;
    logic [V:0]     step_prem;
    logic           step_qbit;
`ifdef CASE_9_SDIV_DIVZERO_FLAG_EN
    logic           dz_q, dz_d;
`endif

    case_9_sdiv_step #(
        .DIVISOR_WIDTH(V)
    ) u_step (
        .prem_i (prem_q),
        .bit_i  (dvd_q[W-1]),
        .dsr_i  (dsr_q),
        .prem_o (step_prem),
        .qbit_o (step_qbit)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dvd_d    = dvd_q;
        dsr_d    = dsr_q;
        prem_d   = prem_q;
        quo_d    = quo_q;
        sgn0_d   = sgn0_q;
        sgn1_d   = sgn1_q;
        quot_d   = quot_q;
        rem_d    = rem_q;
        ap_ready = 1'b0;
`ifdef CASE_9_SDIV_DIVZERO_FLAG_EN
        dz_d     = dz_q;
`endif
        if (ce) begin
            case (state_q)
                IDLE: begin
                    if (ap_start) begin
                        ap_ready = ~ap_rst;
                        // Magnitudes fit unsigned in the operand width, even for the most negative value.
                        dvd_d    = din0[W-1] ? (~din0 + 1'b1) : din0;
                        dsr_d    = {1'b0, (din1[V-1] ? (~din1 + 1'b1) : din1)};
                        sgn0_d   = din0[W-1];
                        sgn1_d   = din1[V-1];
                        prem_d   = '0;
                        quo_d    = '0;
                        cnt_d    = '0;
                        state_d  = CALC;
                    end
                end
                CALC: begin
                    prem_d = step_prem;
                    quo_d  = {quo_q[W-2:0], step_qbit};
                    dvd_d  = {dvd_q[W-2:0], 1'b0};
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == CW'(W - 1)) begin
                        state_d = FIX;
                    end
                end
                FIX: begin
                    quot_d = (sgn0_q ^ sgn1_q) ? (~quo_q + 1'b1) : quo_q;
                    // A zero divisor leaves the low dividend bits in the remainder already.
                    if (dsr_q == '0) begin
                        quot_d = '1;
                    end
                    rem_d  = sgn0_q ? (~prem_q[V-1:0] + 1'b1) : prem_q[V-1:0];
`ifdef CASE_9_SDIV_DIVZERO_FLAG_EN
                    dz_d   = (dsr_q == '0);
`endif
                    state_d = DONE;
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            prem_q  <= '0;
            quo_q   <= '0;
            sgn0_q  <= 1'b0;
            sgn1_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
`ifdef CASE_9_SDIV_DIVZERO_FLAG_EN
            dz_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            prem_q  <= prem_d;
            quo_q   <= quo_d;
            sgn0_q  <= sgn0_d;
            sgn1_q  <= sgn1_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
`ifdef CASE_9_SDIV_DIVZERO_FLAG_EN
            dz_q    <= dz_d;
`endif
        end
    end

    assign ap_idle = (state_q == IDLE);
    assign ap_done = (state_q == DONE);
    assign quot    = quot_q;
    assign rem     = rem_q;
`ifdef CASE_9_SDIV_DIVZERO_FLAG_EN
    assign dz      = dz_q;
`endif

endmodule

// File: tb/tb_case_9_sdiv_17s_9s_17_seq.sv
// Directed self-checking bench for the case_9 sequential signed divider.
// Checks the dz flag as well when CASE_9_SDIV_DIVZERO_FLAG_EN is defined.
module tb_case_9_sdiv_17s_9s_17_seq;

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic        ce;
    logic        ap_start;
    logic        ap_ready;
    logic        ap_idle;
    logic        ap_done;
    logic [16:0] din0;
    logic [8:0]  din1;
    logic [16:0] quot;
    logic [8:0]  rem;
`ifdef CASE_9_SDIV_DIVZERO_FLAG_EN
    logic        dz;
`endif

    int total = 0;
    int bad   = 0;

    always #5 ap_clk = ~ap_clk;

    case_9_sdiv_17s_9s_17_seq #(
        .ID(1),
        .DIVIDEND_WIDTH(17),
        .DIVISOR_WIDTH(9)
    ) dut (
        .ap_clk   (ap_clk),
        .ap_rst   (ap_rst),
        .ce       (ce),
        .ap_start (ap_start),
        .ap_ready (ap_ready),
        .ap_idle  (ap_idle),
        .ap_done  (ap_done),
        .din0     (din0),
        .din1     (din1),
        .quot     (quot),
        .rem      (rem)
`ifdef CASE_9_SDIV_DIVZERO_FLAG_EN
        ,
        .dz       (dz)
`endif
    );

    // Drives one operation; ce is low in cycles [stall_at, stall_at+stall_len) after accept,
    // ap_start is re-pulsed in cycle start_at. Returns with the sim in the ap_done cycle.
    task automatic run_op(input logic [16:0] a, input logic [8:0] b,
                          input int stall_at, input int stall_len, input int start_at,
                          output logic rdy, output logic idl, output int lat, output int extra);
        @(negedge ap_clk);
        din0 = a; din1 = b; ap_start = 1'b1; ce = 1'b1;
        #1;
        rdy = ap_ready; idl = ap_idle; lat = -1; extra = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge ap_clk);
            ap_start = (k == start_at);
            din0 = 17'($urandom);
            din1 = 9'($urandom);
            ce = !(k >= stall_at && k < stall_at + stall_len);
            #1;
            if (ap_ready) extra++;
            if (ap_done) begin
                lat = k;
                break;
            end
        end
        ap_start = 1'b0;
    endtask

    task automatic test_reset();
        ap_rst = 1'b1; ce = 1'b1; ap_start = 1'b1; din0 = 17'd100; din1 = 9'd7;
        repeat (2) @(negedge ap_clk);
        #1;
        total++; if (ap_idle !== 1'b1) begin bad++; $display("FAIL reset_idle got=%b exp=1", ap_idle); end
        total++; if (ap_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", ap_done); end
        total++; if (ap_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", ap_ready); end
        total++; if (quot !== 17'h0) begin bad++; $display("FAIL reset_quot got=%h exp=0", quot); end
        total++; if (rem !== 9'h0) begin bad++; $display("FAIL reset_rem got=%h exp=0", rem); end
`ifdef CASE_9_SDIV_DIVZERO_FLAG_EN
        total++; if (dz !== 1'b0) begin bad++; $display("FAIL reset_dz got=%b exp=0", dz); end
`endif
        @(negedge ap_clk);
        ap_rst = 1'b0; ap_start = 1'b0;
    endtask

    task automatic test_basic();
        logic rdy, idl; int lat, extra;
        run_op(17'd100, 9'd7, 99, 0, 99, rdy, idl, lat, extra);
        total++; if (rdy !== 1'b1) begin bad++; $display("FAIL basic_ready got=%b exp=1", rdy); end
        total++; if (idl !== 1'b1) begin bad++; $display("FAIL basic_idle got=%b exp=1", idl); end
        total++; if (lat != 19) begin bad++; $display("FAIL basic_latency got=%0d exp=19", lat); end
        total++; if (extra != 0) begin bad++; $display("FAIL basic_extra_ready got=%0d exp=0", extra); end
        total++; if (quot !== 17'd14) begin bad++; $display("FAIL basic_quot got=%h exp=%h", quot, 17'd14); end
        total++; if (rem !== 9'd2) begin bad++; $display("FAIL basic_rem got=%h exp=%h", rem, 9'd2); end
        @(negedge ap_clk);
        #1;
        total++; if (ap_done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse got=%b exp=0", ap_done); end
        total++; if (ap_idle !== 1'b1) begin bad++; $display("FAIL basic_back_idle got=%b exp=1", ap_idle); end
        total++; if (quot !== 17'd14) begin bad++; $display("FAIL basic_quot_hold got=%h exp=%h", quot, 17'd14); end
    endtask

    task automatic test_signs();
        logic [16:0] va [3] = '{17'h1FF9C, 17'd100, 17'h1FF9C};
        logic [8:0]  vb [3] = '{9'd7, 9'h1F9, 9'h1F9};
        logic [16:0] eq [3] = '{17'h1FFF2, 17'h1FFF2, 17'd14};
        logic [8:0]  er [3] = '{9'h1FE, 9'd2, 9'h1FE};
        logic rdy, idl; int lat, extra;
        for (int i = 0; i < 3; i++) begin
            run_op(va[i], vb[i], 99, 0, 99, rdy, idl, lat, extra);
            total++; if (lat != 19) begin bad++; $display("FAIL signs_latency[%0d] got=%0d exp=19", i, lat); end
            total++; if (quot !== eq[i]) begin bad++; $display("FAIL signs_quot[%0d] got=%h exp=%h", i, quot, eq[i]); end
            total++; if (rem !== er[i]) begin bad++; $display("FAIL signs_rem[%0d] got=%h exp=%h", i, rem, er[i]); end
        end
    endtask

    task automatic test_overflow();
        logic [16:0] va [2] = '{17'h10000, 17'h10000};
        logic [8:0]  vb [2] = '{9'h1FF, 9'h100};
        logic [16:0] eq [2] = '{17'h10000, 17'h00100};
        logic rdy, idl; int lat, extra;
        for (int i = 0; i < 2; i++) begin
            run_op(va[i], vb[i], 99, 0, 99, rdy, idl, lat, extra);
            total++; if (lat != 19) begin bad++; $display("FAIL ovf_latency[%0d] got=%0d exp=19", i, lat); end
            total++; if (quot !== eq[i]) begin bad++; $display("FAIL ovf_quot[%0d] got=%h exp=%h", i, quot, eq[i]); end
            total++; if (rem !== 9'h0) begin bad++; $display("FAIL ovf_rem[%0d] got=%h exp=0", i, rem); end
        end
    endtask

    task automatic test_divzero();
        logic [16:0] va [3] = '{17'd5, 17'h1FFFB, 17'd9};
        logic [8:0]  vb [3] = '{9'd0, 9'd0, 9'd3};
        logic [16:0] eq [3] = '{17'h1FFFF, 17'h1FFFF, 17'd3};
        logic [8:0]  er [3] = '{9'd5, 9'h1FB, 9'd0};
        logic        ez [3] = '{1'b1, 1'b1, 1'b0};
        logic rdy, idl; int lat, extra;
        for (int i = 0; i < 3; i++) begin
            run_op(va[i], vb[i], 99, 0, 99, rdy, idl, lat, extra);
            total++; if (lat != 19) begin bad++; $display("FAIL dz_latency[%0d] got=%0d exp=19", i, lat); end
            total++; if (quot !== eq[i]) begin bad++; $display("FAIL dz_quot[%0d] got=%h exp=%h", i, quot, eq[i]); end
            total++; if (rem !== er[i]) begin bad++; $display("FAIL dz_rem[%0d] got=%h exp=%h", i, rem, er[i]); end
`ifdef CASE_9_SDIV_DIVZERO_FLAG_EN
            total++; if (dz !== ez[i]) begin bad++; $display("FAIL dz_flag[%0d] got=%b exp=%b", i, dz, ez[i]); end
`else
            if (ez[i] === 1'bx) $display("unreachable");
`endif
        end
    endtask

    task automatic test_ce_stall();
        logic rdy, idl; int lat, extra;
        run_op(17'd100, 9'd7, 5, 5, 3, rdy, idl, lat, extra);
        total++; if (lat != 24) begin bad++; $display("FAIL stall_latency got=%0d exp=24", lat); end
        total++; if (extra != 0) begin bad++; $display("FAIL stall_start_ignored got=%0d exp=0", extra); end
        total++; if (quot !== 17'd14) begin bad++; $display("FAIL stall_quot got=%h exp=%h", quot, 17'd14); end
        total++; if (rem !== 9'd2) begin bad++; $display("FAIL stall_rem got=%h exp=%h", rem, 9'd2); end
        // ce drops in the ap_done cycle: the pulse must stretch until ce returns
        run_op(17'h1FF9C, 9'd7, 19, 1, 99, rdy, idl, lat, extra);
        total++; if (lat != 19) begin bad++; $display("FAIL stretch_latency got=%0d exp=19", lat); end
        @(negedge ap_clk);
        #1;
        total++; if (ap_done !== 1'b1) begin bad++; $display("FAIL stretch_done1 got=%b exp=1", ap_done); end
        @(negedge ap_clk);
        ce = 1'b1;
        #1;
        total++; if (ap_done !== 1'b1) begin bad++; $display("FAIL stretch_done2 got=%b exp=1", ap_done); end
        total++; if (quot !== 17'h1FFF2) begin bad++; $display("FAIL stretch_quot got=%h exp=%h", quot, 17'h1FFF2); end
        @(negedge ap_clk);
        #1;
        total++; if (ap_done !== 1'b0) begin bad++; $display("FAIL stretch_release got=%b exp=0", ap_done); end
        total++; if (ap_idle !== 1'b1) begin bad++; $display("FAIL stretch_idle got=%b exp=1", ap_idle); end
    endtask

    task automatic test_back_to_back();
        logic rdy, idl; int lat, extra;
        run_op(17'h0FFFF, 9'h0FF, 99, 0, 99, rdy, idl, lat, extra);
        total++; if (quot !== 17'h00101) begin bad++; $display("FAIL b2b_quot0 got=%h exp=%h", quot, 17'h00101); end
        total++; if (rem !== 9'd0) begin bad++; $display("FAIL b2b_rem0 got=%h exp=0", rem); end
        run_op(17'h003E8, 9'h1F7, 99, 0, 99, rdy, idl, lat, extra);
        total++; if (rdy !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%b exp=1", rdy); end
        total++; if (idl !== 1'b1) begin bad++; $display("FAIL b2b_idle got=%b exp=1", idl); end
        total++; if (lat != 19) begin bad++; $display("FAIL b2b_latency got=%0d exp=19", lat); end
        total++; if (quot !== 17'h1FF91) begin bad++; $display("FAIL b2b_quot1 got=%h exp=%h", quot, 17'h1FF91); end
        total++; if (rem !== 9'd1) begin bad++; $display("FAIL b2b_rem1 got=%h exp=1", rem); end
    endtask

    task automatic test_reset_abort();
        logic rdy, idl; int lat, extra; logic seen;
        @(negedge ap_clk);
        din0 = 17'd100; din1 = 9'd7; ap_start = 1'b1; ce = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge ap_clk);
            ap_start = 1'b0;
            if (k == 10) ap_rst = 1'b1;
            #1;
            if (k == 5) begin
                total++; if (quot !== 17'h1FF91) begin bad++; $display("FAIL abort_quot_hold got=%h exp=%h", quot, 17'h1FF91); end
            end
        end
        @(negedge ap_clk);
        ap_rst = 1'b0;
        #1;
        total++; if (ap_idle !== 1'b1) begin bad++; $display("FAIL abort_idle got=%b exp=1", ap_idle); end
        total++; if (quot !== 17'h0) begin bad++; $display("FAIL abort_quot got=%h exp=0", quot); end
        total++; if (rem !== 9'h0) begin bad++; $display("FAIL abort_rem got=%h exp=0", rem); end
        seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge ap_clk);
            #1;
            if (ap_done) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL abort_no_done got=%b exp=0", seen); end
        run_op(17'd9, 9'd3, 99, 0, 99, rdy, idl, lat, extra);
        total++; if (lat != 19) begin bad++; $display("FAIL abort_next_latency got=%0d exp=19", lat); end
        total++; if (quot !== 17'd3) begin bad++; $display("FAIL abort_next_quot got=%h exp=3", quot); end
        total++; if (rem !== 9'd0) begin bad++; $display("FAIL abort_next_rem got=%h exp=0", rem); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        ap_rst = 1'b1; ce = 1'b1; ap_start = 1'b0; din0 = '0; din1 = '0;
        test_reset();
        test_basic();
        test_signs();
        test_overflow();
        test_divzero();
        test_ce_stall();
        test_back_to_back();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/case_9_sdiv_17s_9s_17_seq.md
Name: case_9_sdiv_17s_9s_17_seq

Overview:
Sequential signed divider. It is the inverse of the team's combinational case_9 signed multiplier: a 17-bit signed product is divided by a 9-bit signed factor, yielding a 17-bit quotient and a 9-bit remainder. Operation is iterative restoring division, one quotient bit per cycle. The block sits in the case_9 datapath as a multi-cycle functional unit under ap_start/ap_done block-level control with a ce stall input.

Parameters:
- ID, 1, instance identifier; no functional effect.
- DIVIDEND_WIDTH, 17, width of din0 and of the quotient.
- DIVISOR_WIDTH, 9, width of din1 and of the remainder.

Ports:
- ap_clk  in  1  clock; all logic is on the rising edge.
- ap_rst  in  1  synchronous, active-high reset.
- ce  in  1  clock enable; when low, all state and outputs hold.
- ap_start  in  1  request to start; sampled only in IDLE.
- ap_ready  out  1  one-cycle pulse in the cycle the operands are captured.
- ap_idle  out  1  high while in IDLE.
- ap_done  out  1  one-cycle pulse when quot/rem are valid.
- din0  in  DIVIDEND_WIDTH  signed dividend.
- din1  in  DIVISOR_WIDTH  signed divisor.
- quot  out  DIVIDEND_WIDTH  signed quotient; held until the next ap_done.
- rem  out  DIVISOR_WIDTH  signed remainder; held until the next ap_done.

Behaviour:
- Reset: state IDLE; quot, rem, ap_done and ap_ready are 0; ap_idle is 1. Reset wins over ce and ap_start. Reset mid-operation aborts the operation; no ap_done is produced.
- States:
  - IDLE: if ap_start and ce, capture |din0| and |din1| plus both sign bits, clear the partial remainder and iteration counter, pulse ap_ready, then go to CALC.
  - CALC: for DIVIDEND_WIDTH cycles, shift the next dividend bit into the partial remainder. If partial remainder ≥ |divisor|, subtract it and set the quotient bit to 1.
  - FIX: negate the quotient if the operand signs differ. Negate the remainder if the dividend is negative. Register quot and rem.
  - DONE: ap_done=1, then return to IDLE.
- Latency: ap_done occurs DIVIDEND_WIDTH+2 ce-active cycles after the accept cycle, i.e. 19 with defaults. Initiation interval is DIVIDEND_WIDTH+3.
- ap_start outside IDLE is ignored. Inputs are only sampled in the accept cycle.
- ce low: FSM, counter, datapath and ap_done/ap_ready hold their current values. A pending ap_done pulse is stretched while ce is low.
- Semantics: C truncation toward zero. The remainder takes the sign of the dividend.
- Magnitudes: the absolute value of the most negative operand is handled in DIVIDEND_WIDTH+1 / DIVISOR_WIDTH+1 unsigned bits internally.
- Overflow: -2^16 / -1 yields quot = -65536 (0x10000, two's-complement wrap) and rem = 0.
- Divide by zero: quot = all ones (-1), rem = din0[DIVISOR_WIDTH-1:0]. Latency is unchanged.
- Arithmetic: the partial remainder is DIVISOR_WIDTH+1 bits unsigned. Subtraction uses one extra bit for the borrow test.

Optional Feature:
- Macro: CASE_9_SDIV_DIVZERO_FLAG_EN.
- Defined: adds output port dz (1 bit). dz is registered in FIX alongside quot and is 1 when the captured divisor is 0. It is reset to 0 and held until the next ap_done.
- Undefined: no dz port and no zero-detect register. All other behaviour is identical.

Decomposition:
- Package case_9_sdiv_pkg holds:
  - the state enum (IDLE, CALC, FIX, DONE);
  - the width constants DIVIDEND_WIDTH and DIVISOR_WIDTH;
  - the derived counter width clog2(DIVIDEND_WIDTH+1).
- Sub-module case_9_sdiv_step: combinational single restoring step. Inputs are the partial remainder, the incoming bit and the divisor; outputs are the next remainder and the quotient bit. The top module owns the FSM, the counter and sign handling.

Test Plan:
- din0=100, din1=7, ap_start for one cycle, ce=1 → ap_ready in the accept cycle; ap_done 19 cycles later; quot=14, rem=2.
- Sign combinations → -100/7 gives quot=-14, rem=-2; 100/-7 gives -14, 2; -100/-7 gives 14, -2.
- din0=-65536, din1=-1 → quot=0x10000, rem=0. din0=-65536, din1=-256 → quot=256, rem=0.
- din0=5, din1=0 → quot=0x1FFFF, rem=5; dz=1 when CASE_9_SDIV_DIVZERO_FLAG_EN is defined.
- ce held low for 5 cycles mid-CALC → ap_done arrives at cycle 24 with correct results; ap_start pulsed during CALC is ignored (no second ap_ready).
- ap_rst asserted at cycle 10 of an operation → next cycle ap_idle=1 with quot/rem=0 and no ap_done. A following 9/3 operation returns quot=3, rem=0.
